// File: rtl/regfile_wb.sv
// Writeback-stage register file: R0-R14 array, R15 aliased to PC+8, saturating retire counter.
// Optional write-through bypass from W to D read ports under REGFILE_WB_BYPASS_EN.
module regfile_wb (
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWriteW,
   input  logic        MemtoRegW,
   input  logic        PCSrcW,
   input  logic [31:0] ReadDataW,
   input  logic [31:0] ALUOutW,
   input  logic [3:0]  WA3W,
   input  logic [3:0]  RA1D,
   input  logic [3:0]  RA2D,
   input  logic [31:0] PCPlus8D,
   output logic [31:0] RD1D,
   output logic [31:0] RD2D,
   output logic [31:0] ResultW,
   output logic        PCWriteW,
   output logic [31:0] RetireCount
);

   localparam int unsigned NumRegs = 15;
   localparam logic [3:0]  PcAddr  = 4'd15;

   logic [31:0] rf_q [NumRegs];
   logic [31:0] retire_q;
   logic [31:0] retire_d;
   logic        wa_is_pc;
   logic        rf_we;

   assign ResultW  = MemtoRegW ? ReadDataW : ALUOutW;
   assign wa_is_pc = (WA3W == PcAddr);
   assign rf_we    = RegWriteW && !wa_is_pc;
   assign PCWriteW = PCSrcW | (RegWriteW & wa_is_pc);

   // Every committed write retires, including those aimed at the PC; stick at all-ones.
   always_comb begin
      retire_d = retire_q;
      if (RegWriteW && (retire_q != 32'hFFFF_FFFF)) begin
         retire_d = retire_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NumRegs; i++) begin
            rf_q[i] <= '0;
         end
         retire_q <= '0;
      end else begin
         if (rf_we) begin
            rf_q[WA3W] <= ResultW;
         end
         retire_q <= retire_d;
      end
   end

   assign RetireCount = retire_q;

   always_comb begin
      RD1D = '0;
      if (RA1D == PcAddr) begin
         RD1D = PCPlus8D;
`ifdef REGFILE_WB_BYPASS_EN
      end else if (rf_we && (RA1D == WA3W)) begin
         RD1D = ResultW;
`endif
      end else begin
         RD1D = rf_q[RA1D];
      end
   end

   always_comb begin
      RD2D = '0;
      if (RA2D == PcAddr) begin
         RD2D = PCPlus8D;
`ifdef REGFILE_WB_BYPASS_EN
      end else if (rf_we && (RA2D == WA3W)) begin
         RD2D = ResultW;
`endif
      end else begin
         RD2D = rf_q[RA2D];
      end
   end

endmodule

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- RegWriteW  in  1  W-stage register-write enable
- MemtoRegW  in  1  result select: 1 = ReadDataW, 0 = ALUOutW
- PCSrcW  in  1  W-stage result targets the PC
- ReadDataW  in  32  W-stage memory load data
- ALUOutW  in  32  W-stage ALU result
- WA3W  in  4  W-stage destination register number
- RA1D  in  4  D-stage read address, port 1
- RA2D  in  4  D-stage read address, port 2
- PCPlus8D  in  32  D-stage PC+8, returned for R15 reads
- RD1D  out  32  read data, port 1
- RD2D  out  32  read data, port 2
- ResultW  out  32  selected writeback value
- PCWriteW  out  1  writeback redirects the PC this cycle
- RetireCount  out  32  count of committed register writes

Function
REQ-002 ResultW SHALL be combinational: ReadDataW when MemtoRegW=1, otherwise ALUOutW.
REQ-003 The block SHALL hold 15 registers of 32 bits, R0 through R14.
REQ-004 On a rising clk with RegWriteW=1 and WA3W≠15, R[WA3W] SHALL take ResultW.
REQ-005 WA3W=15 with RegWriteW=1 SHALL NOT modify any array entry.
REQ-006 PCWriteW SHALL be combinational: PCSrcW OR (RegWriteW AND WA3W=15).
REQ-007 Reads SHALL be combinational. RDnD = PCPlus8D when RAnD=15, otherwise R[RAnD].
REQ-008 Ports 1 and 2 SHALL be independent; RA1D=RA2D returns identical data on both.
REQ-009 RetireCount SHALL increment by 1 on each rising clk with RegWriteW=1, including WA3W=15.
REQ-010 RetireCount SHALL saturate at 0xFFFFFFFF and never wrap to 0.
REQ-011 PCSrcW=1 with RegWriteW=0 SHALL assert PCWriteW, write no register, and leave RetireCount unchanged.
REQ-012 All X-free inputs SHALL produce X-free outputs one cycle after reset deassertion.

Reset
REQ-013 While reset=1, R0–R14 and RetireCount SHALL be 0, independent of clk.
REQ-014 Reset SHALL take effect immediately, including mid-write; a write coincident with reset assertion SHALL be discarded.
REQ-015 During reset, RDnD SHALL reflect the cleared array: 0, or PCPlus8D for address 15.
REQ-016 On the first rising clk after reset deasserts, writes and counting SHALL resume normally.

Configuration
REQ-017 Macro REGFILE_WB_BYPASS_EN SHALL control write-through bypass.
REQ-018 With REGFILE_WB_BYPASS_EN defined: when RegWriteW=1, WA3W≠15, and RAnD=WA3W, RDnD SHALL return ResultW in the same cycle.
REQ-019 Without REGFILE_WB_BYPASS_EN: RDnD SHALL return the pre-write array value in that cycle. The hazard unit stalls D one extra cycle for such matches.
REQ-020 R15 reads SHALL return PCPlus8D in both configurations.

Verification
REQ-021 Reset pulse mid-cycle after writing R3=0x12345678 -> R3 reads 0 immediately; RetireCount=0.
REQ-022 RegWriteW=1, WA3W=5, MemtoRegW=1, ReadDataW=0xDEADBEEF, ALUOutW=0x1 -> after edge, RA1D=5 gives RD1D=0xDEADBEEF.
REQ-023 Same-cycle write of R7=0xA5A5A5A5 with RA2D=7 -> RD2D=0xA5A5A5A5 with bypass; old R7 value without bypass.
REQ-024 RegWriteW=1, WA3W=15, ALUOutW=0x100 -> PCWriteW=1, no array change, RetireCount+1; RA1D=15 with PCPlus8D=0x208 -> RD1D=0x208.
REQ-025 RetireCount forced to 0xFFFFFFFE, three write cycles -> RetireCount reads 0xFFFFFFFF after each.
REQ-026 PCSrcW=1, RegWriteW=0 -> PCWriteW=1, array and RetireCount unchanged.
